// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: bus widths, fixed encodings and the bridge FSM state type.
// Used by the master bridge, the memory model and the crossbar.
package axi4_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 5;
    localparam int USER_W = 5;
    localparam int LEN_W  = 8;

    localparam logic [1:0] BURST_INCR = 2'h1;
    localparam logic [2:0] SIZE_8B    = 3'h3;
    localparam logic [1:0] RESP_OKAY  = 2'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_AW    = 3'd3,
        ST_W     = 3'd4,
        ST_B     = 3'd5,
        ST_WRESP = 3'd6
    } bridge_state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/axi4_beat_checker.sv
// Burst beat counter with per-beat last/len/resp/id consistency check.
// One instance serves both the read-data and write-data paths of the bridge.
module axi4_beat_checker
    import axi4_pkg::*;
#(
    parameter logic [ID_W-1:0] EXP_ID = 5'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             beat,
    input  logic             last,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       resp,
    input  logic [ID_W-1:0]  id,
    output logic             at_len,
    output logic             beat_err
);

    logic [LEN_W-1:0] cnt_r;

    assign at_len = (cnt_r == len);

    // Flag a beat whose last marker disagrees with the count, or that carries a bad resp/id.
    always_comb begin
        beat_err = 1'b0;
        if (beat) begin
            beat_err = (last != at_len) | (resp != RESP_OKAY) | (id != EXP_ID);
        end else begin
            beat_err = 1'b0;
        end
    end

    // Beats accepted so far in the current burst; saturates rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {LEN_W{1'b0}};
        end else if (beat && (cnt_r != {LEN_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/axi4_master_bridge.sv
// Converts the core's simple request/response bus into single-outstanding AXI4 master
// transactions (INCR bursts, 64-bit beats) and keeps a sticky protocol error flag.
module axi4_master_bridge
    import axi4_pkg::*;
#(
    parameter logic [ID_W-1:0]   AXI_ID   = 5'd0,
    parameter logic [USER_W-1:0] AXI_USER = 5'd0,
    parameter logic [LEN_W-1:0]  MAX_LEN  = 8'd7
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,

    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [7:0]        wd_strb,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_last,
    output logic              resp_write,
    output logic              err,

    output logic [ID_W-1:0]   axi_aw_id,
    output logic [ADDR_W-1:0] axi_aw_addr,
    output logic [LEN_W-1:0]  axi_aw_len,
    output logic [2:0]        axi_aw_size,
    output logic [1:0]        axi_aw_burst,
    output logic              axi_aw_lock,
    output logic [3:0]        axi_aw_cache,
    output logic [2:0]        axi_aw_prot,
    output logic [3:0]        axi_aw_qos,
    output logic [3:0]        axi_aw_region,
    output logic [USER_W-1:0] axi_aw_user,
    output logic              axi_aw_valid,
    input  logic              axi_aw_ready,

    output logic [ID_W-1:0]   axi_w_id,
    output logic [DATA_W-1:0] axi_w_data,
    output logic [7:0]        axi_w_strb,
    output logic              axi_w_last,
    output logic [USER_W-1:0] axi_w_user,
    output logic              axi_w_valid,
    input  logic              axi_w_ready,

    input  logic [ID_W-1:0]   axi_b_id,
    input  logic [1:0]        axi_b_resp,
    input  logic              axi_b_valid,
    output logic              axi_b_ready,

    output logic [ID_W-1:0]   axi_ar_id,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic [LEN_W-1:0]  axi_ar_len,
    output logic [2:0]        axi_ar_size,
    output logic [1:0]        axi_ar_burst,
    output logic              axi_ar_lock,
    output logic [3:0]        axi_ar_cache,
    output logic [2:0]        axi_ar_prot,
    output logic [3:0]        axi_ar_qos,
    output logic [3:0]        axi_ar_region,
    output logic [USER_W-1:0] axi_ar_user,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,

    input  logic [ID_W-1:0]   axi_r_id,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic [1:0]        axi_r_resp,
    input  logic              axi_r_last,
    input  logic              axi_r_valid,
    output logic              axi_r_ready
);

    bridge_state_e     state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic              r_phase_r;
    logic              w_phase_r;
    logic              wresp_r;

    logic              r_fire_s;
    logic              w_fire_s;
    logic              chk_beat_s;
    logic              chk_last_s;
    logic [1:0]        chk_resp_s;
    logic [ID_W-1:0]   chk_id_s;
    logic              at_len_s;
    logic              beat_err_s;
    logic              err_set_s;

    assign axi_ar_id     = AXI_ID;
    assign axi_ar_addr   = addr_r;
    assign axi_ar_len    = len_r;
    assign axi_ar_size   = SIZE_8B;
    assign axi_ar_burst  = BURST_INCR;
    assign axi_ar_lock   = 1'b0;
    assign axi_ar_cache  = 4'h0;
    assign axi_ar_prot   = 3'h0;
    assign axi_ar_qos    = 4'h0;
    assign axi_ar_region = 4'h0;
    assign axi_ar_user   = AXI_USER;

    assign axi_aw_id     = AXI_ID;
    assign axi_aw_addr   = addr_r;
    assign axi_aw_len    = len_r;
    assign axi_aw_size   = SIZE_8B;
    assign axi_aw_burst  = BURST_INCR;
    assign axi_aw_lock   = 1'b0;
    assign axi_aw_cache  = 4'h0;
    assign axi_aw_prot   = 3'h0;
    assign axi_aw_qos    = 4'h0;
    assign axi_aw_region = 4'h0;
    assign axi_aw_user   = AXI_USER;

    // Data paths are pure pass-through while their phase flag is set, adding no latency.
    assign axi_w_id    = AXI_ID;
    assign axi_w_user  = AXI_USER;
    assign axi_w_data  = wd_data;
    assign axi_w_strb  = wd_strb;
    assign axi_w_valid = w_phase_r & wd_valid;
    assign axi_w_last  = w_phase_r & at_len_s;
    assign wd_ready    = w_phase_r & axi_w_ready;

    assign axi_r_ready = r_phase_r & resp_ready;
    assign resp_valid  = r_phase_r ? axi_r_valid : wresp_r;
    assign resp_rdata  = r_phase_r ? axi_r_data : {DATA_W{1'b0}};
    assign resp_last   = r_phase_r ? axi_r_last : wresp_r;
    assign resp_write  = wresp_r;

    assign r_fire_s   = axi_r_valid & axi_r_ready;
    assign w_fire_s   = axi_w_valid & axi_w_ready;
    assign chk_beat_s = r_phase_r ? r_fire_s : w_fire_s;
    assign chk_last_s = r_phase_r ? axi_r_last : at_len_s;
    assign chk_resp_s = r_phase_r ? axi_r_resp : RESP_OKAY;
    assign chk_id_s   = r_phase_r ? axi_r_id : AXI_ID;

    axi4_beat_checker #(
        .EXP_ID (AXI_ID)
    ) u_beat_checker (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_r == ST_IDLE),
        .beat     (chk_beat_s),
        .last     (chk_last_s),
        .len      (len_r),
        .resp     (chk_resp_s),
        .id       (chk_id_s),
        .at_len   (at_len_s),
        .beat_err (beat_err_s)
    );

    // Collect every condition that raises the sticky error in the current state.
    always_comb begin
        err_set_s = 1'b0;
        case (state_r)
            ST_IDLE:   err_set_s = req_valid & ((req_len > MAX_LEN) | (req_addr[2:0] != 3'b000));
            ST_R,
            ST_W:      err_set_s = beat_err_s;
            ST_B:      err_set_s = axi_b_valid & ((axi_b_resp != RESP_OKAY) | (axi_b_id != AXI_ID));
            default:   err_set_s = 1'b0;
        endcase
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= err | err_set_s;
        end
    end

    // Transaction sequencer; every handshake-facing control output is a register here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            req_ready    <= 1'b1;
            axi_ar_valid <= 1'b0;
            axi_aw_valid <= 1'b0;
            axi_b_ready  <= 1'b0;
            r_phase_r    <= 1'b0;
            w_phase_r    <= 1'b0;
            wresp_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r    <= req_addr;
                        len_r     <= clamp_len(req_len, MAX_LEN);
                        req_ready <= 1'b0;
                        if (req_write) begin
                            state_r      <= ST_AW;
                            axi_aw_valid <= 1'b1;
                        end else begin
                            state_r      <= ST_AR;
                            axi_ar_valid <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (axi_ar_ready) begin
                        axi_ar_valid <= 1'b0;
                        r_phase_r    <= 1'b1;
                        state_r      <= ST_R;
                    end
                end
                ST_R: begin
                    // A premature or late r_last only raises err; the burst ends on r_last.
                    if (r_fire_s && axi_r_last) begin
                        r_phase_r <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (axi_aw_ready) begin
                        axi_aw_valid <= 1'b0;
                        w_phase_r    <= 1'b1;
                        state_r      <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_fire_s && at_len_s) begin
                        w_phase_r   <= 1'b0;
                        axi_b_ready <= 1'b1;
                        state_r     <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi_b_valid) begin
                        axi_b_ready <= 1'b0;
                        wresp_r     <= 1'b1;
                        state_r     <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (resp_ready) begin
                        wresp_r   <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready    <= 1'b1;
                    axi_ar_valid <= 1'b0;
                    axi_aw_valid <= 1'b0;
                    axi_b_ready  <= 1'b0;
                    r_phase_r    <= 1'b0;
                    w_phase_r    <= 1'b0;
                    wresp_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Self-checking bench for axi4_master_bridge: a randomly stalling AXI slave memory plus a
// word-array reference memory; directed and random read/write bursts are compared beat by beat.
module tb_axi4_master_bridge;
    import axi4_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        resp_valid, resp_ready, resp_last, resp_write, err;
    logic [63:0] resp_rdata;

    logic [4:0]  axi_aw_id, axi_aw_user, axi_w_id, axi_w_user, axi_b_id;
    logic [31:0] axi_aw_addr;
    logic [7:0]  axi_aw_len;
    logic [2:0]  axi_aw_size, axi_aw_prot;
    logic [1:0]  axi_aw_burst, axi_b_resp;
    logic        axi_aw_lock, axi_aw_valid, axi_aw_ready;
    logic [3:0]  axi_aw_cache, axi_aw_qos, axi_aw_region;
    logic [63:0] axi_w_data;
    logic [7:0]  axi_w_strb;
    logic        axi_w_last, axi_w_valid, axi_w_ready, axi_b_valid, axi_b_ready;
    logic [4:0]  axi_ar_id, axi_ar_user, axi_r_id;
    logic [31:0] axi_ar_addr;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size, axi_ar_prot;
    logic [1:0]  axi_ar_burst, axi_r_resp;
    logic        axi_ar_lock, axi_ar_valid, axi_ar_ready;
    logic [3:0]  axi_ar_cache, axi_ar_qos, axi_ar_region;
    logic [63:0] axi_r_data;
    logic        axi_r_last, axi_r_valid, axi_r_ready;

    axi4_master_bridge dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_last(resp_last), .resp_write(resp_write), .err(err),
        .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock),
        .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos),
        .axi_aw_region(axi_aw_region), .axi_aw_user(axi_aw_user),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
        .axi_w_id(axi_w_id), .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
        .axi_w_last(axi_w_last), .axi_w_user(axi_w_user),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
        .axi_b_ready(axi_b_ready),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock),
        .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos),
        .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
    );

    // ---------------- AXI slave memory with random stalls ----------------
    logic [63:0] smem [0:1023];
    logic        load_en;
    int          load_idx;
    logic [63:0] load_val;
    int          inj_last = -1;
    logic        inj_id = 1'b0;
    logic        rd_busy, b_pend;
    logic [31:0] rd_addr, wr_addr;
    logic [7:0]  rd_beat, rd_len, wr_beat;
    logic [9:0]  rd_idx, wr_idx;

    assign rd_idx     = rd_addr[12:3] + {2'b00, rd_beat};
    assign wr_idx     = wr_addr[12:3] + {2'b00, wr_beat};
    assign axi_r_data = smem[rd_idx];
    assign axi_r_last = (inj_last >= 0) ? (int'(rd_beat) == inj_last) : (rd_beat == rd_len);
    assign axi_r_id   = inj_id ? 5'd1 : 5'd0;
    assign axi_r_resp = 2'b00;
    assign axi_b_id   = 5'd0;
    assign axi_b_resp = 2'b00;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] s);
        logic [63:0] v;
        v = old;
        for (int b = 0; b < 8; b++) if (s[b]) v[b*8 +: 8] = nw[b*8 +: 8];
        return v;
    endfunction

    always @(posedge clock) begin
        if (load_en) smem[load_idx] <= load_val;
        if (reset) begin
            axi_ar_ready <= 1'b0; axi_aw_ready <= 1'b0; axi_w_ready <= 1'b0;
            axi_r_valid  <= 1'b0; axi_b_valid  <= 1'b0;
            rd_busy <= 1'b0; b_pend <= 1'b0; rd_beat <= 8'd0; wr_beat <= 8'd0;
            rd_addr <= 32'd0; wr_addr <= 32'd0; rd_len <= 8'd0;
        end else begin
            axi_ar_ready <= ($urandom_range(0, 3) != 0);
            axi_aw_ready <= ($urandom_range(0, 3) != 0);
            axi_w_ready  <= ($urandom_range(0, 3) != 0);
            if (axi_ar_valid && axi_ar_ready) begin
                rd_busy <= 1'b1; rd_addr <= axi_ar_addr; rd_len <= axi_ar_len; rd_beat <= 8'd0;
            end
            if (rd_busy) begin
                if (!axi_r_valid) axi_r_valid <= ($urandom_range(0, 2) != 0);
                else if (axi_r_ready) begin
                    if (axi_r_last) begin
                        rd_busy <= 1'b0; axi_r_valid <= 1'b0;
                    end else begin
                        rd_beat <= rd_beat + 8'd1; axi_r_valid <= ($urandom_range(0, 2) != 0);
                    end
                end
            end
            if (axi_aw_valid && axi_aw_ready) begin
                wr_addr <= axi_aw_addr; wr_beat <= 8'd0;
            end
            if (axi_w_valid && axi_w_ready) begin
                smem[wr_idx] <= merge(smem[wr_idx], axi_w_data, axi_w_strb);
                wr_beat <= wr_beat + 8'd1;
                if (axi_w_last) b_pend <= 1'b1;
            end
            if (b_pend && !axi_b_valid) axi_b_valid <= ($urandom_range(0, 1) != 0);
            else if (axi_b_valid && axi_b_ready) begin
                axi_b_valid <= 1'b0; b_pend <= 1'b0;
            end
        end
    end

    // ---------------- reference model and checks ----------------
    int          total = 0;
    int          bad = 0;
    logic [63:0] model_mem [0:1023];
    logic [63:0] rd_seen [0:7];
    logic [63:0] wdata [0:7];
    logic [7:0]  wstrb [0:7];
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rr_value(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0];
            2:       return ($urandom_range(0, 1) != 0);
            default: return (cyc % 8) >= 5;
        endcase
    endfunction

    task automatic send_req(input logic w, input logic [31:0] a, input logic [7:0] l);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; n = 0;
        while (!req_ready && n < 50) begin @(negedge clock); n++; end
        chk("req_accept", 64'(n < 50), 64'd1);
        @(negedge clock);
        req_valid = 1'b0;
        if (l > 8'd7 || a[2:0] != 3'b000) exp_err = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int mode,
                           input int last_at);
        int L, lastidx, i, cyc;
        logic done, saw_ar, ar_pend;
        L = (l > 8'd7) ? 7 : int'(l);
        lastidx = (last_at >= 0) ? last_at : L;
        inj_last = last_at;
        send_req(1'b0, a, l);
        if (lastidx != L) exp_err = 1'b1;
        i = 0; cyc = 0; done = 1'b0; saw_ar = 1'b0; ar_pend = 1'b0;
        while (!done && cyc < 2000) begin
            resp_ready = rr_value(mode, cyc);
            if (ar_pend) chk("ar_hold", 64'(axi_ar_valid), 64'd1);
            ar_pend = axi_ar_valid && !axi_ar_ready;
            if (axi_ar_valid && !saw_ar) begin
                chk("ar_addr", 64'(axi_ar_addr), 64'(a));
                chk("ar_len", 64'(axi_ar_len), 64'(L));
                chk("ar_size_burst", 64'({axi_ar_size, axi_ar_burst}), 64'({3'h3, 2'h1}));
                saw_ar = 1'b1;
            end
            if (resp_valid && resp_ready) begin
                chk("rd_data", resp_rdata, model_mem[(int'(a[12:3]) + i) % 1024]);
                chk("rd_last", 64'(resp_last), 64'(i == lastidx));
                chk("rd_write", 64'(resp_write), 64'd0);
                if (i < 8) rd_seen[i] = resp_rdata;
                if (resp_last) done = 1'b1;
                i++;
            end
            @(negedge clock); cyc++;
        end
        resp_ready = 1'b0; inj_last = -1;
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_beats", 64'(i), 64'(lastidx + 1));
        chk("rd_idle_ready", 64'(req_ready), 64'd1);
        chk("rd_err", 64'(err), 64'(exp_err));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input int gap,
                            input int rmode);
        int L, i, cyc, gapc, idx;
        logic done, saw_aw, aw_pend, aw_done;
        logic [63:0] m;
        L = (l > 8'd7) ? 7 : int'(l);
        send_req(1'b1, a, l);
        i = 0; cyc = 0; gapc = 0; saw_aw = 1'b0; aw_pend = 1'b0; aw_done = 1'b0;
        while (i <= L && cyc < 2000) begin
            if (gapc > 0) begin
                wd_valid = 1'b0; gapc--;
            end else begin
                wd_valid = 1'b1; wd_data = wdata[i]; wd_strb = wstrb[i];
            end
            #1;
            if (aw_pend) chk("aw_hold", 64'(axi_aw_valid), 64'd1);
            aw_pend = axi_aw_valid && !axi_aw_ready;
            if (axi_aw_valid && !saw_aw) begin
                chk("aw_addr", 64'(axi_aw_addr), 64'(a));
                chk("aw_len", 64'(axi_aw_len), 64'(L));
                saw_aw = 1'b1;
            end
            if (!aw_done) chk("w_before_aw", 64'(axi_w_valid), 64'd0);
            if (axi_aw_valid && axi_aw_ready) aw_done = 1'b1;
            if (wd_valid && wd_ready) begin
                chk("w_last", 64'(axi_w_last), 64'(i == L));
                chk("w_data", axi_w_data, wdata[i]);
                idx = (int'(a[12:3]) + i) % 1024;
                for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{wstrb[i][b]}};
                model_mem[idx] = (model_mem[idx] & ~m) | (wdata[i] & m);
                i++; gapc = gap;
            end
            @(negedge clock); cyc++;
        end
        wd_valid = 1'b0;
        chk("wr_beats", 64'(i), 64'(L + 1));
        done = 1'b0; cyc = 0;
        while (!done && cyc < 2000) begin
            resp_ready = rr_value(rmode, cyc);
            if (resp_valid && resp_ready) begin
                chk("wack_write", 64'(resp_write), 64'd1);
                chk("wack_last", 64'(resp_last), 64'd1);
                chk("wack_rdata", resp_rdata, 64'd0);
                done = 1'b1;
            end
            @(negedge clock); cyc++;
        end
        resp_ready = 1'b0;
        chk("wr_done", 64'(done), 64'd1);
        chk("wr_idle_ready", 64'(req_ready), 64'd1);
        chk("wr_err", 64'(err), 64'(exp_err));
    endtask

    task automatic fill_write(input int strb_mode);
        for (int k = 0; k < 8; k++) begin
            wdata[k] = {$urandom, $urandom};
            wstrb[k] = (strb_mode == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        int i, cyc, len, word;
        logic [31:0] upper_old;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_len = 8'd0;
        wd_valid = 1'b0; wd_data = 64'd0; wd_strb = 8'd0; resp_ready = 1'b0;
        load_en = 1'b0; load_idx = 0; load_val = 64'd0; exp_err = 1'b0;

        for (int k = 0; k < 1024; k++) model_mem[k] = {$urandom, $urandom};
        model_mem[32'h20] = 64'hDEADBEEF_00000001;
        for (int k = 0; k < 8; k++) model_mem[512 + k] = 64'h200 + 64'(k);
        @(negedge clock);
        for (int k = 0; k < 1024; k++) begin
            load_en = 1'b1; load_idx = k; load_val = model_mem[k];
            @(negedge clock);
        end
        load_en = 1'b0;
        @(negedge clock);

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ar_valid", 64'(axi_ar_valid), 64'd0);
        chk("rst_aw_valid", 64'(axi_aw_valid), 64'd0);
        chk("rst_wd_ready", 64'(wd_ready), 64'd0);
        chk("rst_b_ready", 64'(axi_b_ready), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        do_read(32'h100, 8'd0, 0, -1);
        do_read(32'h1000, 8'd7, 1, -1);

        fill_write(0);
        wstrb[2] = 8'h0F;
        upper_old = model_mem[32'h400 + 2][63:32];
        do_write(32'h2000, 8'd3, 0, 0);
        do_read(32'h2000, 8'd3, 2, -1);
        chk("strb_upper_kept", 64'(rd_seen[2][63:32]), 64'(upper_old));
        chk("strb_lower_written", 64'(rd_seen[2][31:0]), 64'(wdata[2][31:0]));

        fill_write(1);
        do_write(32'h3000, 8'd7, 3, 3);
        do_read(32'h3000, 8'd7, 3, -1);

        for (int k = 0; k < 12; k++) begin
            len  = $urandom_range(0, 7);
            word = $urandom_range(0, 1023 - len);
            if ($urandom_range(0, 1) != 0) begin
                fill_write(1);
                do_write(32'(word) << 3, 8'(len), $urandom_range(0, 2), 2);
            end else begin
                do_read(32'(word) << 3, 8'(len), 2, -1);
            end
        end

        do_read(32'h1000, 8'd20, 0, -1);

        // reset on the fourth read beat
        send_req(1'b0, 32'h1000, 8'd7);
        resp_ready = 1'b1; i = 0; cyc = 0;
        while (i < 4 && cyc < 500) begin
            if (resp_valid) i++;
            @(negedge clock); cyc++;
        end
        chk("pre_reset_beats", 64'(i), 64'd4);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ar_valid", 64'(axi_ar_valid), 64'd0);
        chk("mid_rst_aw_valid", 64'(axi_aw_valid), 64'd0);
        chk("mid_rst_w_valid", 64'(axi_w_valid), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_err", 64'(err), 64'd0);
        reset = 1'b0; resp_ready = 1'b0; exp_err = 1'b0;
        @(negedge clock);
        do_read(32'h1000, 8'd7, 0, -1);

        do_read(32'h1000, 8'd7, 2, 3);

        reset = 1'b1; @(negedge clock); reset = 1'b0; exp_err = 1'b0; @(negedge clock);
        do_read(32'h104, 8'd0, 0, -1);

        reset = 1'b1; @(negedge clock); reset = 1'b0; @(negedge clock);
        exp_err = 1'b1; inj_id = 1'b1;
        do_read(32'h100, 8'd0, 0, -1);
        inj_id = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
